// File: rtl/jk_driver_pkg.sv
// Shared types and constants for the JK flip-flop bank driver.
// The excitation codes are packed as {j, k}.
package jk_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [1:0] EXC_HOLD = 2'b00;
    localparam logic [1:0] EXC_SET  = 2'b10;
    localparam logic [1:0] EXC_RST  = 2'b01;
    localparam logic [1:0] EXC_TGL  = 2'b11;

endpackage

// File: rtl/jk_driver_excite.sv
// Per-bit JK excitation: chooses j/k that move q towards tgt when drive is high.
// Optional macro JK_DRIVER_TOGGLE_EN: use toggle (j=k=1) on mismatching bits
// instead of the set/reset encoding.
import jk_driver_pkg::*;

module jk_excite (
    input  logic tgt,
    input  logic q,
    input  logic drive,
    output logic j,
    output logic k
);

    logic [1:0] exc_s;

    // Select the excitation code for this bit from target and current q.
    always_comb begin
        exc_s = EXC_HOLD;
        if (drive) begin
`ifdef JK_DRIVER_TOGGLE_EN
            if (tgt != q) begin
                exc_s = EXC_TGL;
            end else begin
                exc_s = EXC_HOLD;
            end
`else
            case ({tgt, q})
                2'b10:   exc_s = EXC_SET;
                2'b01:   exc_s = EXC_RST;
                default: exc_s = EXC_HOLD;
            endcase
`endif
        end else begin
            exc_s = EXC_HOLD;
        end
    end

    assign j = exc_s[1];
    assign k = exc_s[0];

endmodule

// File: rtl/jk_driver.sv
// Drives an external bank of JK flip-flops to a requested state, checks the
// fed-back q values, and retries up to RETRY_MAX times before flagging err.
// j/k are registered: they are computed on the edge entering DRIVE from the
// q_fb seen then, which is stable because the bank is held (j=k=0) outside DRIVE.
// Optional macro JK_DRIVER_TOGGLE_EN selects toggle excitation (see jk_excite).
import jk_driver_pkg::*;

module jk_driver #(
    parameter int WIDTH     = 4,
    parameter int RETRY_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err
);

    // RETRY_MAX = 0 still needs a 1-bit counter to keep the logic well formed.
    localparam int CNT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(RETRY_MAX);

    state_t           state_r;
    logic [WIDTH-1:0] tgt_r;
    logic [CNT_W-1:0] retry_cnt_r;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic             done_r;
    logic             err_r;

    logic [WIDTH-1:0] tgt_nx_s;
    logic             drive_nx_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;

    // Decide whether the next cycle is DRIVE and which target it will use.
    always_comb begin
        tgt_nx_s   = tgt_r;
        drive_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    tgt_nx_s   = req_target;
                    drive_nx_s = 1'b1;
                end else begin
                    drive_nx_s = 1'b0;
                end
            end
            CHECK: begin
                if ((q_fb != tgt_r) && (retry_cnt_r < RETRY_LIM)) begin
                    drive_nx_s = 1'b1;
                end else begin
                    drive_nx_s = 1'b0;
                end
            end
            default: drive_nx_s = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_exc
            jk_excite u_exc (
                .tgt   (tgt_nx_s[gi]),
                .q     (q_fb[gi]),
                .drive (drive_nx_s),
                .j     (j_s[gi]),
                .k     (k_s[gi])
            );
        end
    endgenerate

    // Request/drive/check sequencer with registered excitation and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            tgt_r       <= '0;
            retry_cnt_r <= '0;
            j_r         <= '0;
            k_r         <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            j_r    <= j_s;
            k_r    <= k_s;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        tgt_r       <= req_target;
                        retry_cnt_r <= '0;
                        state_r     <= DRIVE;
                    end
                end
                DRIVE: begin
                    state_r <= CHECK;
                end
                CHECK: begin
                    if (q_fb == tgt_r) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end else if (retry_cnt_r < RETRY_LIM) begin
                        retry_cnt_r <= retry_cnt_r + CNT_W'(1);
                        state_r     <= DRIVE;
                    end else begin
                        state_r <= IDLE;
                        err_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_r == IDLE) && !reset;
    assign j         = j_r;
    assign k         = k_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
